uart_ram_transmitter: RTL and testbench
=======================================

UART_RAM_TRANSMITTER -- requirements
Module: uart_ram_transmitter

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, giving clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter NUM_BYTES, default 512, giving bytes sent per transfer.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, giving the RAM address width.
REQ-004 SHALL use one clock and a synchronous, active-low reset, on ports Clock and Resetn as below.
REQ-005 Clock  input  1  50 MHz system clock; all state updates on the rising edge.
REQ-006 Resetn  input  1  synchronous active-low reset, sampled on the rising edge of Clock.
REQ-007 Start_I  input  1  transfer request, sampled in IDLE only.
REQ-008 RAM_address_O  output  ADDR_WIDTH  read address to the DP-RAM port.
REQ-009 RAM_read_data_I  input  8  RAM read data, valid one cycle after the address is presented.
REQ-010 UART_TX_O  output  1  serial line, idle high.
REQ-011 Busy_O  output  1  high whenever the state is not IDLE.
REQ-012 Done_O  output  1  one-cycle pulse after the last stop bit of a transfer.

Function
REQ-013 SHALL implement the states IDLE, READ_WAIT, LOAD, START_BIT, DATA, STOP and DONE.
REQ-014 IDLE: UART_TX_O=1; when Start_I=1, RAM_address_O<=0, byte counter<=0 and next state READ_WAIT.
REQ-015 READ_WAIT: one cycle for the RAM read latency, then LOAD.
REQ-016 LOAD: latch RAM_read_data_I into the 8-bit shift register, clear the baud counter and bit index, then START_BIT.
REQ-017 START_BIT: UART_TX_O=0 for exactly BAUD_DIV cycles, then DATA.
REQ-018 DATA: UART_TX_O = shift_reg[0], held BAUD_DIV cycles per bit; shift right after each bit; 8 bits LSB-first; then STOP.
REQ-019 STOP: UART_TX_O=1 for BAUD_DIV cycles.
REQ-020 STOP exit when byte counter = NUM_BYTES-1: next state DONE.
REQ-021 STOP exit otherwise: increment byte counter and RAM_address_O, then READ_WAIT.
REQ-022 DONE: Done_O=1 for exactly one cycle, then IDLE; Busy_O=1 while in DONE.
REQ-023 The baud counter SHALL count 0..BAUD_DIV-1 and wrap to 0; a bit boundary occurs at the count BAUD_DIV-1.
REQ-024 Byte period SHALL be 10*BAUD_DIV+2 cycles (READ_WAIT + LOAD + 10 bit times); consecutive bytes have no extra idle.
REQ-025 The address SHALL wrap modulo 2^ADDR_WIDTH; NUM_BYTES <= 2^ADDR_WIDTH.
REQ-026 Start_I asserted outside IDLE SHALL be ignored and not queued; Start_I high in the cycle of IDLE re-entry starts a new transfer.
REQ-027 Start_I held high continuously SHALL give back-to-back transfers: DONE, then one IDLE cycle, then a restart.
REQ-028 UART_TX_O SHALL be driven from a register (glitch-free).

Reset
REQ-029 Resetn=0 at a rising edge SHALL set state=IDLE, UART_TX_O=1, RAM_address_O=0, byte counter=0, baud counter=0, Busy_O=0 and Done_O=0.
REQ-030 Reset in mid-frame SHALL abort the frame immediately; the line goes high on the next edge and no Done_O pulse is produced.
REQ-031 After reset release, the block SHALL stay idle until a new Start_I.

Verification
REQ-032 NUM_BYTES=4, BAUD_DIV=8, RAM[0..3]=55,A3,00,FF, pulse Start_I -> serial frames decode to 55,A3,00,FF, each with start=0 and stop=1.
REQ-033 Same setup -> each bit lasts exactly 8 cycles, each byte period is 82 cycles, and Done_O pulses once, 4*82+1 cycles after Start_I is sampled.
REQ-034 Start_I pulsed again at byte 2 -> ignored; exactly 4 bytes are sent; Busy_O falls after DONE.
REQ-035 Resetn low during DATA bit 3 of byte 1 -> UART_TX_O=1 next cycle, RAM_address_O=0, no Done_O; a new Start_I resends from byte 0.
REQ-036 NUM_BYTES=512, ADDR_WIDTH=9 -> RAM_address_O steps 0..511, last byte read from address 511, Done_O is a single pulse.
REQ-037 Start_I held high -> two consecutive transfers, with 1 IDLE cycle between the Done_O pulse and the next READ_WAIT.

Source files
------------

// File: rtl/uart_ram_transmitter.sv
// Streams NUM_BYTES bytes from a synchronous-read DP-RAM port out of a UART
// transmitter (8N1, LSB first), one transfer per accepted Start_I.
//
// Ports:
//   Clock            system clock; all state changes on the rising edge
//   Resetn           synchronous active-low reset
//   Start_I          transfer request, only honoured in IDLE
//   RAM_address_O    registered read address to the RAM
//   RAM_read_data_I  RAM data, valid one cycle after the address
//   UART_TX_O        registered serial line, idle high
//   Busy_O           high whenever the FSM is not in IDLE
//   Done_O           one-cycle pulse (the DONE state) after the last stop bit
module uart_ram_transmitter #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned NUM_BYTES  = 512,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start_I,
  output logic [ADDR_WIDTH-1:0] RAM_address_O,
  input  logic [7:0]            RAM_read_data_I,
  output logic                  UART_TX_O,
  output logic                  Busy_O,
  output logic                  Done_O
);

  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  BYTE_LAST = CNT_W'(NUM_BYTES - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] READ_WAIT = 3'd1;
  localparam logic [2:0] LOAD      = 3'd2;
  localparam logic [2:0] START_BIT = 3'd3;
  localparam logic [2:0] DATA      = 3'd4;
  localparam logic [2:0] STOP      = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  logic [2:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]            bit_idx_q,  bit_idx_d;
  logic [7:0]            shift_q,    shift_d;
  logic                  tx_q,       tx_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  logic                  baud_end;
  logic [BAUD_W-1:0]     baud_next;

  // Bit-time boundary and wrapping baud count
  assign baud_end  = (baud_cnt_q == BAUD_LAST);
  assign baud_next = baud_end ? '0 : baud_cnt_q + BAUD_W'(1);

  // State register with all datapath registers
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start_I) begin
          addr_d     = '0;
          byte_cnt_d = '0;
          state_d    = READ_WAIT;
        end
      end
      READ_WAIT: state_d = LOAD;
      LOAD: begin
        shift_d    = RAM_read_data_I;
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        state_d    = START_BIT;
      end
      START_BIT: begin
        baud_cnt_d = baud_next;
        if (baud_end) state_d = DATA;
      end
      DATA: begin
        baud_cnt_d = baud_next;
        if (baud_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        baud_cnt_d = baud_next;
        if (baud_end) begin
          if (byte_cnt_q == BYTE_LAST) begin
            state_d = DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            addr_d     = addr_q + ADDR_WIDTH'(1);
            state_d    = READ_WAIT;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registers line up
    // with the state they describe.
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = shift_d[0];
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign RAM_address_O = addr_q;
  assign UART_TX_O     = tx_q;
  assign Busy_O        = busy_q;
  assign Done_O        = done_q;

endmodule

// File: tb/tb_uart_ram_transmitter.sv
// Directed bench for uart_ram_transmitter: a 4-byte / BAUD_DIV=8 instance
// checked cycle by cycle against a frame table, and a 512-byte / BAUD_DIV=2
// instance for the full address sweep.
module tb_uart_ram_transmitter;

  logic       clock_50;
  logic       rst_n;

  logic       start_a, tx_a, busy_a, done_a;
  logic [8:0] addr_a;
  logic [7:0] rdata_a;
  logic [7:0] mem_a [512];

  logic       start_b, tx_b, busy_b, done_b;
  logic [8:0] addr_b;
  logic [7:0] rdata_b;
  logic [7:0] mem_b [512];

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] ram;
    logic [9:0] frame;  // line values in send order: [0]=start, [8:1]=data, [9]=stop
  } vec_t;
  vec_t vecs [4];

  uart_ram_transmitter #(.BAUD_DIV(8), .NUM_BYTES(4), .ADDR_WIDTH(9)) dut_a (
    .Clock(clock_50), .Resetn(rst_n), .Start_I(start_a),
    .RAM_address_O(addr_a), .RAM_read_data_I(rdata_a),
    .UART_TX_O(tx_a), .Busy_O(busy_a), .Done_O(done_a)
  );

  uart_ram_transmitter #(.BAUD_DIV(2), .NUM_BYTES(512), .ADDR_WIDTH(9)) dut_b (
    .Clock(clock_50), .Resetn(rst_n), .Start_I(start_b),
    .RAM_address_O(addr_b), .RAM_read_data_I(rdata_b),
    .UART_TX_O(tx_b), .Busy_O(busy_b), .Done_O(done_b)
  );

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  // Synchronous-read RAM models
  always @(posedge clock_50) begin
    rdata_a <= mem_a[addr_a];
    rdata_b <= mem_b[addr_b];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // One transfer on dut_a. Cycle n=1 is the cycle after the edge that samples
  // Start_I; byte k fills cycles 82k+1..82k+82, DONE is cycle 329.
  // poke_n re-asserts Start_I for one cycle mid-transfer (0 = never).
  task automatic run_xfer(input int poke_n, input string tag);
    int tx_err = 0, busy_err = 0, addr_err = 0, done_cnt = 0, done_n = 0;
    int k, p, b, j;
    logic exp_tx;
    logic [9:0] cap [4];
    for (int i = 0; i < 4; i++) cap[i] = '0;
    @(negedge clock_50); start_a = 1'b1;
    @(posedge clock_50); #1;
    start_a = 1'b0;
    for (int n = 1; n <= 345; n++) begin
      start_a = (n == poke_n);
      if (n <= 328) begin
        k = (n - 1) / 82;
        p = (n - 1) % 82;
        if (p < 2) exp_tx = 1'b1;
        else begin
          b = (p - 2) / 8;
          j = (p - 2) % 8;
          exp_tx = vecs[k].frame[b];
          if (j == 4) cap[k][b] = tx_a;
        end
        if (addr_a !== 9'(k)) addr_err++;
      end else begin
        exp_tx = 1'b1;
        if (addr_a !== 9'd3) addr_err++;
      end
      if (tx_a !== exp_tx) tx_err++;
      if (busy_a !== (n <= 329)) busy_err++;
      if (done_a === 1'b1) begin done_cnt++; done_n = n; end
      @(posedge clock_50); #1;
    end
    start_a = 1'b0;
    for (int i = 0; i < 4; i++)
      check($sformatf("%s frame%0d", tag, i), 32'(cap[i]), 32'(vecs[i].frame));
    check({tag, " tx cycle errors"}, tx_err, 0);
    check({tag, " busy cycle errors"}, busy_err, 0);
    check({tag, " address errors"}, addr_err, 0);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " done cycle"}, done_n, 329);
  endtask

  initial begin
    int cnt_busy, cnt_done, d1, d2, addr_err, tx_err, last_addr;
    logic b330, b331;
    logic [8:0] a330, a331;
    int k, p, b;
    logic exp_tx;
    logic [7:0] data;

    vecs[0] = '{8'h55, 10'b1010101010};
    vecs[1] = '{8'hA3, 10'b1101000110};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'hFF, 10'b1111111110};
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'(i) ^ 8'h5A;
    end
    for (int i = 0; i < 4; i++) mem_a[i] = vecs[i].ram;

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clock_50);
    #1;
    check("reset tx", 32'(tx_a), 1);
    check("reset addr", 32'(addr_a), 0);
    check("reset busy", 32'(busy_a), 0);
    check("reset done", 32'(done_a), 0);

    // Stays idle after release without a request
    rst_n = 1'b1;
    cnt_busy = 0;
    repeat (20) begin
      @(posedge clock_50); #1;
      if (busy_a !== 1'b0 || tx_a !== 1'b1) cnt_busy++;
    end
    check("idle after release", cnt_busy, 0);

    run_xfer(0, "xfer1");
    run_xfer(82 * 2 + 10, "poke");

    // Reset during data bit 3 of byte 1 (cycle 120, line carries A3 bit3 = 0)
    @(negedge clock_50); start_a = 1'b1;
    @(posedge clock_50); #1;
    start_a = 1'b0;
    repeat (119) @(posedge clock_50);
    #1;
    check("pre-reset tx", 32'(tx_a), 0);
    check("pre-reset addr", 32'(addr_a), 1);
    rst_n = 1'b0;
    @(posedge clock_50); #1;
    check("mid-frame reset tx", 32'(tx_a), 1);
    check("mid-frame reset addr", 32'(addr_a), 0);
    check("mid-frame reset busy", 32'(busy_a), 0);
    check("mid-frame reset done", 32'(done_a), 0);
    repeat (2) @(posedge clock_50);
    #1;
    rst_n = 1'b1;
    cnt_busy = 0; cnt_done = 0;
    repeat (40) begin
      @(posedge clock_50); #1;
      if (busy_a === 1'b1) cnt_busy++;
      if (done_a === 1'b1) cnt_done++;
    end
    check("post-reset busy", cnt_busy, 0);
    check("post-reset done", cnt_done, 0);
    run_xfer(0, "resend");

    // Start held high: DONE at 329, IDLE at 330, second READ_WAIT at 331
    @(negedge clock_50); start_a = 1'b1;
    @(posedge clock_50); #1;
    cnt_done = 0; d1 = 0; d2 = 0;
    b330 = 1'b1; b331 = 1'b0; a330 = '0; a331 = '1;
    for (int n = 1; n <= 670; n++) begin
      start_a = (n < 331);
      if (done_a === 1'b1) begin
        cnt_done++;
        if (cnt_done == 1) d1 = n; else d2 = n;
      end
      if (n == 330) begin b330 = busy_a; a330 = addr_a; end
      if (n == 331) begin b331 = busy_a; a331 = addr_a; end
      @(posedge clock_50); #1;
    end
    start_a = 1'b0;
    check("held done pulses", cnt_done, 2);
    check("held first done", d1, 329);
    check("held second done", d2, 659);
    check("held idle busy", 32'(b330), 0);
    check("held idle addr", 32'(a330), 3);
    check("held restart busy", 32'(b331), 1);
    check("held restart addr", 32'(a331), 0);

    // 512-byte sweep, BAUD_DIV=2: byte period 22, DONE at 512*22+1
    @(negedge clock_50); start_b = 1'b1;
    @(posedge clock_50); #1;
    start_b = 1'b0;
    addr_err = 0; tx_err = 0; cnt_done = 0; d1 = 0; last_addr = 0;
    for (int n = 1; n <= 11270; n++) begin
      if (n <= 11264) begin
        k = (n - 1) / 22;
        p = (n - 1) % 22;
        data = 8'(k) ^ 8'h5A;
        if (p < 2) exp_tx = 1'b1;
        else begin
          b = (p - 2) / 2;
          if (b == 0) exp_tx = 1'b0;
          else if (b == 9) exp_tx = 1'b1;
          else exp_tx = data[b-1];
        end
        if (addr_b !== 9'(k)) addr_err++;
        if (n == 11264) last_addr = int'(addr_b);
      end else exp_tx = 1'b1;
      if (tx_b !== exp_tx) tx_err++;
      if (done_b === 1'b1) begin cnt_done++; d1 = n; end
      @(posedge clock_50); #1;
    end
    check("sweep address errors", addr_err, 0);
    check("sweep tx errors", tx_err, 0);
    check("sweep last address", last_addr, 511);
    check("sweep done pulses", cnt_done, 1);
    check("sweep done cycle", d1, 11265);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
